issue_scheduler: RTL and testbench

//  - Wakeup/select controller for the dynamic-core issue queue. Tracks the operand readiness of each queue slot.
//  - Snoops CDB result tags, then picks the oldest fully-ready slot and presents its index to one functional unit (FU) over a valid/ready handshake.
//  - On acceptance, pulses a free request so the issue queue deallocates the slot.
//  - Sits between the issue queue (slot storage), the CDB and the FU dispatch port.

---
 rtl/issue_scheduler_pkg.sv | 20 ++
 rtl/issue_scheduler_age_select.sv | 22 ++
 rtl/issue_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_issue_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue-queue wakeup/select controller.
package issue_pkg;

    localparam int TAG_WIDTH_DEF = 6;
    // Slot tags are stored at this width; narrower tags are zero-extended on entry.
    localparam int MAX_TAG_W     = 16;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        WAIT   = 2'd1,
        READY  = 2'd2,
        ISSUED = 2'd3
    } slot_state_e;

    typedef struct packed {
        logic [MAX_TAG_W-1:0] tag;
        logic                 rdy;
    } slot_src_t;

endpackage

// File: rtl/issue_scheduler_age_select.sv
// Oldest-first picker: grants the ready slot that no other ready slot is older than.
module age_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]       i_ready,
    input  logic [DEPTH*DEPTH-1:0] i_older,
    output logic [DEPTH-1:0]       o_grant,
    output logic                   o_valid
);

    // Bit (j*DEPTH + i) is older[j][i]; the diagonal is always zero, so no self-exclusion is needed.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_col
        logic [DEPTH-1:0] w_older_than_i;
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_row
            assign w_older_than_i[gj] = i_older[gj*DEPTH + gi];
        end
        assign o_grant[gi] = i_ready[gi] & ~|(w_older_than_i & i_ready);
    end

    assign o_valid = |o_grant;

endmodule

// File: rtl/issue_scheduler.sv
// Wakeup/select controller: tracks per-slot operand readiness, snoops the CDB and
// issues the oldest ready slot to one FU over a valid/ready handshake.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int  DEPTH     = 16,
    parameter int  TAG_WIDTH = TAG_WIDTH_DEF,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc_valid,
    input  logic [IDX_W-1:0]     alloc_idx,
    input  logic [TAG_WIDTH-1:0] alloc_s1_tag,
    input  logic                 alloc_s1_rdy,
    input  logic [TAG_WIDTH-1:0] alloc_s2_tag,
    input  logic                 alloc_s2_rdy,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    output logic                 issue_valid,
    output logic [IDX_W-1:0]     issue_idx,
    input  logic                 issue_ready,
    output logic                 free_valid,
    output logic [IDX_W-1:0]     free_idx,
    output logic [DEPTH-1:0]     slot_busy
);

    localparam logic [1:0] S_EMPTY  = EMPTY;
    localparam logic [1:0] S_WAIT   = WAIT;
    localparam logic [1:0] S_READY  = READY;
    localparam logic [1:0] S_ISSUED = ISSUED;

    logic [1:0]                  r_state [DEPTH];
    slot_src_t                   r_src1  [DEPTH];
    slot_src_t                   r_src2  [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic                        r_issue_valid;
    logic [IDX_W-1:0]            r_issue_idx;
    logic                        r_free_valid;
    logic [IDX_W-1:0]            r_free_idx;

    logic [DEPTH-1:0]     w_busy;
    logic [DEPTH-1:0]     w_ready;
    logic [DEPTH-1:0]     w_wake1;
    logic [DEPTH-1:0]     w_wake2;
    logic [DEPTH-1:0]     w_grant;
    logic                 w_sel_valid;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_hs;
    logic                 w_load;
    logic                 w_cap;
    logic                 w_alloc_r1;
    logic                 w_alloc_r2;
    logic [MAX_TAG_W-1:0] w_cdb_tag;

    assign w_cdb_tag  = MAX_TAG_W'(cdb_tag);
    assign w_hs       = r_issue_valid & issue_ready;
    assign w_load     = ~r_issue_valid | issue_ready;
    assign w_cap      = w_load & w_sel_valid;
    // A source produced by the broadcast in the same cycle is stored already ready.
    assign w_alloc_r1 = alloc_s1_rdy | (cdb_valid & (alloc_s1_tag == cdb_tag));
    assign w_alloc_r2 = alloc_s2_rdy | (cdb_valid & (alloc_s2_tag == cdb_tag));

    always_comb begin
        w_busy  = '0;
        w_ready = '0;
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy[i]  = (r_state[i] != S_EMPTY);
            w_ready[i] = (r_state[i] == S_READY);
            w_wake1[i] = cdb_valid && (r_state[i] == S_WAIT) && (r_src1[i].tag == w_cdb_tag);
            w_wake2[i] = cdb_valid && (r_state[i] == S_WAIT) && (r_src2[i].tag == w_cdb_tag);
        end
    end

    age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .i_ready (w_ready),
        .i_older (r_older),
        .o_grant (w_grant),
        .o_valid (w_sel_valid)
    );

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_idx = w_sel_idx | IDX_W'(i);
            end
        end
    end

    // Alloc takes priority over every other transition, including a same-slot handshake.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= S_EMPTY;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_valid && (alloc_idx == IDX_W'(i))) begin
                    r_state[i] <= (w_alloc_r1 && w_alloc_r2) ? S_READY : S_WAIT;
                end else begin
                    case (r_state[i])
                        S_WAIT: begin
                            if ((r_src1[i].rdy || w_wake1[i]) && (r_src2[i].rdy || w_wake2[i])) begin
                                r_state[i] <= S_READY;
                            end
                        end
                        S_READY: begin
                            if (w_cap && w_grant[i]) begin
                                r_state[i] <= S_ISSUED;
                            end
                        end
                        S_ISSUED: begin
                            if (w_hs && (r_issue_idx == IDX_W'(i))) begin
                                r_state[i] <= S_EMPTY;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_valid && (alloc_idx == IDX_W'(i))) begin
                r_src1[i] <= '{tag: MAX_TAG_W'(alloc_s1_tag), rdy: w_alloc_r1};
                r_src2[i] <= '{tag: MAX_TAG_W'(alloc_s2_tag), rdy: w_alloc_r2};
            end else begin
                if (w_wake1[i]) begin
                    r_src1[i].rdy <= 1'b1;
                end
                if (w_wake2[i]) begin
                    r_src2[i].rdy <= 1'b1;
                end
            end
        end
    end

    // The newcomer is younger than everything currently occupied; clearing its row last keeps the diagonal zero.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_older <= '0;
        end else if (alloc_valid) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_older[j][alloc_idx] <= w_busy[j];
            end
            r_older[alloc_idx] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_valid <= 1'b0;
            r_issue_idx   <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_load) begin
            r_issue_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_issue_idx <= w_sel_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_free_valid <= 1'b0;
            r_free_idx   <= '0;
        end else begin
            r_free_valid <= w_hs & ~flush;
            if (w_hs && !flush) begin
                r_free_idx <= r_issue_idx;
            end
        end
    end

    // Reallocating an occupied slot is only legal when that slot is being handed off this cycle.
    always @(posedge clk) begin
        if (!reset && !flush && alloc_valid) begin
            assert (!w_busy[alloc_idx] || (w_hs && (r_issue_idx == alloc_idx)));
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_idx   = r_issue_idx;
    assign free_valid  = r_free_valid;
    assign free_idx    = r_free_idx;
    assign slot_busy   = w_busy;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed and randomized bench for issue_scheduler against an age-sequence reference model.
module tb_issue_scheduler;

    localparam int DEPTH     = 16;
    localparam int TAG_WIDTH = 6;
    localparam int IDX_W     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 alloc_valid;
    logic [IDX_W-1:0]     alloc_idx;
    logic [TAG_WIDTH-1:0] alloc_s1_tag;
    logic                 alloc_s1_rdy;
    logic [TAG_WIDTH-1:0] alloc_s2_tag;
    logic                 alloc_s2_rdy;
    logic                 cdb_valid;
    logic [TAG_WIDTH-1:0] cdb_tag;
    logic                 issue_valid;
    logic [IDX_W-1:0]     issue_idx;
    logic                 issue_ready;
    logic                 free_valid;
    logic [IDX_W-1:0]     free_idx;
    logic [DEPTH-1:0]     slot_busy;

    issue_scheduler #(
        .DEPTH     (DEPTH),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_idx    (alloc_idx),
        .alloc_s1_tag (alloc_s1_tag),
        .alloc_s1_rdy (alloc_s1_rdy),
        .alloc_s2_tag (alloc_s2_tag),
        .alloc_s2_rdy (alloc_s2_rdy),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .issue_valid  (issue_valid),
        .issue_idx    (issue_idx),
        .issue_ready  (issue_ready),
        .free_valid   (free_valid),
        .free_idx     (free_idx),
        .slot_busy    (slot_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy, operand readiness and an allocation sequence number per slot.
    bit                   m_busy [DEPTH];
    bit                   m_r1   [DEPTH];
    bit                   m_r2   [DEPTH];
    bit                   m_iss  [DEPTH];
    int unsigned          m_seq  [DEPTH];
    logic [TAG_WIDTH-1:0] m_t1   [DEPTH];
    logic [TAG_WIDTH-1:0] m_t2   [DEPTH];
    int unsigned          seq_cnt = 0;
    bit                   m_iv = 1'b0;
    bit                   m_fv = 1'b0;
    logic [IDX_W-1:0]     m_ii = '0;
    logic [IDX_W-1:0]     m_fi = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit hs;
        bit ld;
        int sel;
        int k;
        hs  = m_iv && issue_ready;
        ld  = !m_iv || issue_ready;
        sel = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && m_r1[i] && m_r2[i] && !m_iss[i]) begin
                if (sel < 0) sel = i;
                else if (m_seq[i] < m_seq[sel]) sel = i;
            end
        end
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_busy[i] = 1'b0;
                m_iss[i]  = 1'b0;
            end
            m_iv = 1'b0; m_ii = '0; m_fv = 1'b0; m_fi = '0;
        end else begin
            m_fv = hs && !flush;
            if (m_fv) m_fi = m_ii;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_busy[i] = 1'b0;
                    m_iss[i]  = 1'b0;
                end
                m_iv = 1'b0;
            end else begin
                if (cdb_valid) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (m_busy[i] && m_t1[i] == cdb_tag) m_r1[i] = 1'b1;
                        if (m_busy[i] && m_t2[i] == cdb_tag) m_r2[i] = 1'b1;
                    end
                end
                if (hs) begin
                    m_busy[m_ii] = 1'b0;
                    m_iss[m_ii]  = 1'b0;
                end
                if (ld) begin
                    m_iv = (sel >= 0);
                    if (sel >= 0) begin
                        m_ii       = IDX_W'(sel);
                        m_iss[sel] = 1'b1;
                    end
                end
                if (alloc_valid) begin
                    k         = int'(alloc_idx);
                    m_busy[k] = 1'b1;
                    m_iss[k]  = 1'b0;
                    m_seq[k]  = seq_cnt;
                    seq_cnt++;
                    m_t1[k]   = alloc_s1_tag;
                    m_t2[k]   = alloc_s2_tag;
                    m_r1[k]   = alloc_s1_rdy || (cdb_valid && cdb_tag == alloc_s1_tag);
                    m_r2[k]   = alloc_s2_rdy || (cdb_valid && cdb_tag == alloc_s2_tag);
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [DEPTH-1:0] bv;
        for (int i = 0; i < DEPTH; i++) bv[i] = m_busy[i];
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(m_iv));
        chk({tag, ".issue_idx"},   32'(issue_idx),   32'(m_ii));
        chk({tag, ".free_valid"},  32'(free_valid),  32'(m_fv));
        chk({tag, ".free_idx"},    32'(free_idx),    32'(m_fi));
        chk({tag, ".slot_busy"},   32'(slot_busy),   32'(bv));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        reset       = 1'b0;
        flush       = 1'b0;
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
    endtask

    task automatic set_alloc(input int idx, input int t1, input bit r1, input int t2, input bit r2);
        alloc_valid  = 1'b1;
        alloc_idx    = IDX_W'(idx);
        alloc_s1_tag = TAG_WIDTH'(t1);
        alloc_s1_rdy = r1;
        alloc_s2_tag = TAG_WIDTH'(t2);
        alloc_s2_rdy = r2;
    endtask

    initial begin
        int s;
        int pick;
        reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_idx = '0;
        alloc_s1_tag = '0; alloc_s1_rdy = 1'b0; alloc_s2_tag = '0; alloc_s2_rdy = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; issue_ready = 1'b0;
        step("rst0");
        step("rst1");
        chk("rst.issue_valid", 32'(issue_valid), 0);
        chk("rst.issue_idx",   32'(issue_idx),   0);
        chk("rst.free_valid",  32'(free_valid),  0);
        chk("rst.slot_busy",   32'(slot_busy),   0);

        // Both sources ready: issue two edges after the alloc, free one cycle after the handshake.
        idle(); issue_ready = 1'b1;
        set_alloc(3, 0, 1'b1, 0, 1'b1);  step("t1a");
        chk("t1.early_valid", 32'(issue_valid), 0);
        idle();                          step("t1b");
        chk("t1.issue_valid", 32'(issue_valid), 1);
        chk("t1.issue_idx",   32'(issue_idx),   3);
        step("t1c");
        chk("t1.free_valid",  32'(free_valid),  1);
        chk("t1.free_idx",    32'(free_idx),    3);
        step("t1d");
        chk("t1.free_pulse",  32'(free_valid),  0);

        // Wakeup through the CDB.
        set_alloc(5, 0, 1'b1, 'h0A, 1'b0); step("t2a");
        idle(); step("t2b"); step("t2c");
        chk("t2.no_early_issue", 32'(issue_valid), 0);
        cdb_valid = 1'b1; cdb_tag = 6'h0A; step("t2w");
        chk("t2.not_yet", 32'(issue_valid), 0);
        idle(); step("t2d");
        chk("t2.issue_valid", 32'(issue_valid), 1);
        chk("t2.issue_idx",   32'(issue_idx),   5);
        step("t2e");

        // Age ordering with back-to-back handshakes.
        set_alloc(7, 0, 1'b1, 0, 1'b1); step("t3a");
        set_alloc(2, 0, 1'b1, 0, 1'b1); step("t3b");
        chk("t3.first",  32'(issue_idx), 7);
        set_alloc(9, 0, 1'b1, 0, 1'b1); step("t3c");
        chk("t3.second", 32'(issue_idx), 2);
        chk("t3.free7",  32'(free_idx),  7);
        idle(); step("t3d");
        chk("t3.third",  32'(issue_idx), 9);
        chk("t3.free2",  32'(free_idx),  2);
        step("t3e");
        chk("t3.drained", 32'(issue_valid), 0);
        chk("t3.free9",   32'(free_idx),    9);

        // Held output while the FU stalls and an older slot wakes.
        issue_ready = 1'b0;
        set_alloc(1, 'h20, 1'b0, 0, 1'b1); step("t4a");
        set_alloc(4, 0, 1'b1, 0, 1'b1);    step("t4b");
        idle(); step("t4c");
        chk("t4.issue4", 32'(issue_idx), 4);
        cdb_valid = 1'b1; cdb_tag = 6'h20; step("t4d");
        idle(); step("t4e"); step("t4f");
        chk("t4.held_idx",   32'(issue_idx),   4);
        chk("t4.held_valid", 32'(issue_valid), 1);
        issue_ready = 1'b1; step("t4g");
        chk("t4.older_next", 32'(issue_idx), 1);
        chk("t4.free4",      32'(free_idx),  4);
        step("t4h");

        // Same-cycle CDB bypass on alloc.
        set_alloc(6, 'h11, 1'b0, 0, 1'b1); cdb_valid = 1'b1; cdb_tag = 6'h11; step("t5a");
        idle(); step("t5b");
        chk("t5.issue_valid", 32'(issue_valid), 1);
        chk("t5.issue_idx",   32'(issue_idx),   6);
        step("t5c");

        // Flush beats a concurrent alloc.
        issue_ready = 1'b0;
        set_alloc(0, 0, 1'b1, 0, 1'b1);    step("t6a");
        set_alloc(1, 'h3F, 1'b0, 0, 1'b1); step("t6b");
        set_alloc(2, 'h3F, 1'b0, 0, 1'b1); step("t6c");
        set_alloc(3, 'h3F, 1'b0, 0, 1'b1); step("t6d");
        chk("t6.busy4", 32'(slot_busy), 32'h000F);
        flush = 1'b1; set_alloc(8, 0, 1'b1, 0, 1'b1); cdb_valid = 1'b1; cdb_tag = 6'h3F; step("t6e");
        chk("t6.busy_cleared",  32'(slot_busy),   0);
        chk("t6.valid_cleared", 32'(issue_valid), 0);
        idle(); step("t6f");
        chk("t6.slot8_absent",  32'(slot_busy),   0);

        // Alloc into the slot being handed off this cycle.
        set_alloc(10, 0, 1'b1, 0, 1'b1); step("t7a");
        idle(); step("t7b");
        chk("t7.issue10", 32'(issue_idx), 10);
        issue_ready = 1'b1; set_alloc(10, 5, 1'b0, 0, 1'b1); step("t7c");
        chk("t7.realloc_busy", 32'(slot_busy[10]), 1);
        chk("t7.no_reissue",   32'(issue_valid),   0);
        chk("t7.free10",       32'(free_idx),      10);
        idle(); cdb_valid = 1'b1; cdb_tag = 6'h05; step("t7d");
        idle(); step("t7e");
        chk("t7.reissue10", 32'(issue_idx), 10);
        step("t7f");

        // Randomized traffic, with occasional flush and one mid-run reset.
        for (int c = 0; c < 400; c++) begin
            idle();
            issue_ready = ($urandom_range(9) < 7);
            if ($urandom_range(59) == 0) flush = 1'b1;
            if (c == 200) reset = 1'b1;
            cdb_valid = 1'($urandom_range(1));
            cdb_tag   = 6'($urandom_range(7));
            if ($urandom_range(1) == 1) begin
                s    = int'($urandom_range(DEPTH-1));
                pick = -1;
                for (int k = 0; k < DEPTH; k++) begin
                    if (pick < 0 && !m_busy[(s + k) % DEPTH]) pick = (s + k) % DEPTH;
                end
                if (pick >= 0) begin
                    set_alloc(pick, int'($urandom_range(7)), 1'($urandom_range(1)),
                              int'($urandom_range(7)), 1'($urandom_range(1)));
                end
            end
            step("rnd");
        end

        idle(); issue_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            cdb_valid = 1'b1;
            cdb_tag   = 6'(c % 8);
            step("drain");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
